// File: rtl/lcds_bp_pkg.sv
// Shared types and constants for the LCDS hardware breakpoint unit.
// Slot configuration bundle, global FSM state and the status-byte bit layout.
package lcds_bp_pkg;

    localparam int STATUS_FETCH_BIT = 5;
    localparam int BP_CNT_MAX_W     = 16;

    typedef enum logic [1:0] {
        ARMED   = 2'd0,
        FIRED   = 2'd1,
        INDEBUG = 2'd2
    } bp_state_t;

    // count is carried at its maximum width; each slot keeps only CNT_W bits
    typedef struct packed {
        logic                    en;
        logic                    fetch_only;
        logic                    rearm;
        logic [15:0]             addr;
        logic [15:0]             mask;
        logic [BP_CNT_MAX_W-1:0] count;
    } bp_cfg_t;

endpackage

// File: rtl/lcds_bp_slot.sv
// One breakpoint slot: config registers, pass counter and fire decision.
// A config write in the same cycle as a match takes priority over counting or firing.
module lcds_bp_slot
    import lcds_bp_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic        clk,
    input  logic        RST_n,
    input  logic        i_we,
    input  bp_cfg_t     i_cfg,
    input  logic        i_qual,
    input  logic [15:0] i_addr,
    input  logic [7:0]  i_data,
    input  logic        i_armed,
    input  logic        i_reload,
    output logic        o_fire
);

    logic             r_en;
    logic             r_fetch_only;
    logic             r_rearm;
    logic [15:0]      r_addr;
    logic [15:0]      r_mask;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_reload;

    logic w_match;
    logic w_hit;

    assign w_match = r_en && i_qual
                  && (((i_addr ^ r_addr) & ~r_mask) == 16'h0000)
                  && (!r_fetch_only || i_data[STATUS_FETCH_BIT]);
    assign w_hit   = i_armed && w_match && !i_we;
    assign o_fire  = w_hit && (r_count == '0);

    always_ff @(posedge clk) begin
        if (!RST_n) begin
            r_en         <= 1'b0;
            r_fetch_only <= 1'b0;
            r_rearm      <= 1'b0;
            r_addr       <= '0;
            r_mask       <= '0;
            r_count      <= '0;
            r_reload     <= '0;
        end else if (i_we) begin
            r_en         <= i_cfg.en;
            r_fetch_only <= i_cfg.fetch_only;
            r_rearm      <= i_cfg.rearm;
            r_addr       <= i_cfg.addr;
            r_mask       <= i_cfg.mask;
            r_count      <= CNT_W'(i_cfg.count);
            r_reload     <= CNT_W'(i_cfg.count);
        end else if (i_reload && r_rearm) begin
            r_count <= r_reload;
        end else if (w_hit) begin
            if (r_count != '0)
                r_count <= r_count - 1'b1;
            else if (!r_rearm)
                r_en <= 1'b0;
        end
    end

endmodule

// File: rtl/lcds_breakpoint.sv
// Hardware breakpoint unit: qualifies SC/MP bus cycles, checks all slots and
// requests debug entry via DEBUG_n until the debug block acknowledges with INDBG_n.
//
// state   | meaning
// ARMED   | slots evaluated on every qualified bus cycle
// FIRED   | DEBUG_n held low, waiting for INDBG_n low
// INDEBUG | debug monitor running, matches ignored; rearm slots reload on exit
module lcds_breakpoint
    import lcds_bp_pkg::*;
#(
    parameter int NUM_BP = 2,
    parameter int CNT_W  = 8,
    localparam int SEL_W = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
    input  logic             clk,
    input  logic             RST_n,
    input  logic             ADS_n,
    input  logic [7:0]       data,
    input  logic [15:0]      cpu_addr,
    input  logic             INDBG_n,
    input  logic             cfg_we,
    input  logic [SEL_W-1:0] cfg_sel,
    input  logic             cfg_en,
    input  logic             cfg_fetch_only,
    input  logic             cfg_rearm,
    input  logic [15:0]      cfg_addr,
    input  logic [15:0]      cfg_mask,
    input  logic [CNT_W-1:0] cfg_count,
    output logic             DEBUG_n,
    output logic [SEL_W-1:0] bp_hit_id,
    output logic             bp_hit_valid
);

    bp_state_t        r_state;
    bp_state_t        w_state_nxt;
    logic             r_ads_q;
    logic [SEL_W-1:0] r_hit_id;
    logic             r_hit_valid;

    logic              w_qual;
    logic              w_armed;
    logic              w_reload;
    logic [NUM_BP-1:0] w_fire;
    logic              w_any_fire;
    logic [SEL_W-1:0]  w_fire_id;
    bp_cfg_t           w_cfg;

    // only the falling edge of ADS_n counts, however long the strobe stays low
    assign w_qual = !ADS_n && r_ads_q;

    assign w_cfg = '{en: cfg_en, fetch_only: cfg_fetch_only, rearm: cfg_rearm,
                     addr: cfg_addr, mask: cfg_mask, count: BP_CNT_MAX_W'(cfg_count)};

    for (genvar g = 0; g < NUM_BP; g++) begin : g_slot
        lcds_bp_slot #(.CNT_W(CNT_W)) u_slot (
            .clk      (clk),
            .RST_n    (RST_n),
            .i_we     (cfg_we && (cfg_sel == SEL_W'(g))),
            .i_cfg    (w_cfg),
            .i_qual   (w_qual),
            .i_addr   (cpu_addr),
            .i_data   (data),
            .i_armed  (w_armed),
            .i_reload (w_reload),
            .o_fire   (w_fire[g])
        );
    end

    always_comb begin
        w_any_fire = 1'b0;
        w_fire_id  = '0;
        for (int i = NUM_BP - 1; i >= 0; i--) begin
            if (w_fire[i]) begin
                w_any_fire = 1'b1;
                w_fire_id  = SEL_W'(i);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_armed     = 1'b0;
        w_reload    = 1'b0;
        case (r_state)
            ARMED: begin
                w_armed = 1'b1;
                if (w_any_fire)
                    w_state_nxt = FIRED;
                else if (!INDBG_n)
                    w_state_nxt = INDEBUG;
            end
            FIRED: begin
                if (!INDBG_n)
                    w_state_nxt = INDEBUG;
            end
            INDEBUG: begin
                if (INDBG_n) begin
                    w_state_nxt = ARMED;
                    w_reload    = 1'b1;
                end
            end
            default: w_state_nxt = ARMED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!RST_n) begin
            r_state     <= ARMED;
            r_ads_q     <= 1'b1;
            r_hit_id    <= '0;
            r_hit_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ads_q <= ADS_n;
            if (w_armed && w_any_fire) begin
                r_hit_id    <= w_fire_id;
                r_hit_valid <= 1'b1;
            end
        end
    end

    assign DEBUG_n      = (r_state != FIRED);
    assign bp_hit_id    = r_hit_id;
    assign bp_hit_valid = r_hit_valid;

endmodule

// File: tb/tb_lcds_breakpoint.sv
// Directed testbench for lcds_breakpoint: drives bus cycles and config writes
// one clk at a time and compares outputs against hand-computed values.
module tb_lcds_breakpoint;

    localparam int NUM_BP = 2;
    localparam int CNT_W  = 8;

    logic        clk = 1'b0;
    logic        RST_n;
    logic        ADS_n;
    logic [7:0]  data;
    logic [15:0] cpu_addr;
    logic        INDBG_n;
    logic        cfg_we;
    logic [0:0]  cfg_sel;
    logic        cfg_en;
    logic        cfg_fetch_only;
    logic        cfg_rearm;
    logic [15:0] cfg_addr;
    logic [15:0] cfg_mask;
    logic [7:0]  cfg_count;
    logic        DEBUG_n;
    logic [0:0]  bp_hit_id;
    logic        bp_hit_valid;

    int checks = 0;
    int errors = 0;

    lcds_breakpoint #(.NUM_BP(NUM_BP), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .RST_n          (RST_n),
        .ADS_n          (ADS_n),
        .data           (data),
        .cpu_addr       (cpu_addr),
        .INDBG_n        (INDBG_n),
        .cfg_we         (cfg_we),
        .cfg_sel        (cfg_sel),
        .cfg_en         (cfg_en),
        .cfg_fetch_only (cfg_fetch_only),
        .cfg_rearm      (cfg_rearm),
        .cfg_addr       (cfg_addr),
        .cfg_mask       (cfg_mask),
        .cfg_count      (cfg_count),
        .DEBUG_n        (DEBUG_n),
        .bp_hit_id      (bp_hit_id),
        .bp_hit_valid   (bp_hit_valid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        RST_n = 1'b0;
        tick();
        tick();
        RST_n = 1'b1;
    endtask

    task automatic cfg(input int sel, input logic en, input logic fo, input logic re,
                       input logic [15:0] a, input logic [15:0] m, input logic [7:0] c);
        cfg_sel        = 1'(sel);
        cfg_en         = en;
        cfg_fetch_only = fo;
        cfg_rearm      = re;
        cfg_addr       = a;
        cfg_mask       = m;
        cfg_count      = c;
        cfg_we         = 1'b1;
        tick();
        cfg_we = 1'b0;
    endtask

    // one bus cycle with ADS_n low for n clk; fired = DEBUG_n low one clk after the strobe
    task automatic bus(input logic [15:0] a, input logic [7:0] d, input int n, output logic fired);
        cpu_addr = a;
        data     = d;
        ADS_n    = 1'b0;
        tick();
        fired = !DEBUG_n;
        for (int i = 1; i < n; i++) tick();
        ADS_n = 1'b1;
        tick();
    endtask

    task automatic dbg_cycle();
        INDBG_n = 1'b0;
        tick();
        INDBG_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (DEBUG_n !== 1'b1) begin errors++; $display("FAIL reset_debug_n: got %b want 1", DEBUG_n); end
        checks++;
        if (bp_hit_valid !== 1'b0) begin errors++; $display("FAIL reset_hit_valid: got %b want 0", bp_hit_valid); end
        checks++;
        if (bp_hit_id !== 1'b0) begin errors++; $display("FAIL reset_hit_id: got %b want 0", bp_hit_id); end
    endtask

    task automatic test_basic();
        logic f;
        do_reset();
        cfg(0, 1'b1, 1'b1, 1'b0, 16'h1234, 16'h0000, 8'd0);
        bus(16'h1234, 8'h00, 1, f);
        checks++;
        if (f !== 1'b0) begin errors++; $display("FAIL basic_nonfetch: fired %b want 0", f); end
        bus(16'h1235, 8'h20, 1, f);
        checks++;
        if (f !== 1'b0) begin errors++; $display("FAIL basic_wrong_addr: fired %b want 0", f); end
        cpu_addr = 16'h1234;
        data     = 8'h20;
        ADS_n    = 1'b0;
        #2;
        checks++;
        if (DEBUG_n !== 1'b1) begin errors++; $display("FAIL basic_qual_cycle: DEBUG_n %b want 1", DEBUG_n); end
        tick();
        checks++;
        if (DEBUG_n !== 1'b0) begin errors++; $display("FAIL basic_latency: DEBUG_n %b want 0", DEBUG_n); end
        checks++;
        if (bp_hit_id !== 1'b0 || bp_hit_valid !== 1'b1)
            begin errors++; $display("FAIL basic_hit: id %b valid %b want 0 1", bp_hit_id, bp_hit_valid); end
        tick();
        tick();
        ADS_n = 1'b1;
        tick();
        checks++;
        if (DEBUG_n !== 1'b0) begin errors++; $display("FAIL basic_hold: DEBUG_n %b want 0", DEBUG_n); end
        INDBG_n = 1'b0;
        tick();
        checks++;
        if (DEBUG_n !== 1'b1) begin errors++; $display("FAIL basic_ack: DEBUG_n %b want 1", DEBUG_n); end
        INDBG_n = 1'b1;
        tick();
        bus(16'h1234, 8'h20, 1, f);
        checks++;
        if (f !== 1'b0) begin errors++; $display("FAIL basic_oneshot: fired %b want 0", f); end
    endtask

    task automatic test_pass_count();
        logic f;
        logic exp_f;
        do_reset();
        cfg(1, 1'b1, 1'b1, 1'b1, 16'h4000, 16'h0000, 8'd2);
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 3; k++) begin
                bus(16'h4000, 8'h20, 2, f);
                exp_f = (k == 2);
                checks++;
                if (f !== exp_f) begin errors++; $display("FAIL pass_count r%0d k%0d: fired %b want %b", r, k, f, exp_f); end
            end
            checks++;
            if (bp_hit_id !== 1'b1) begin errors++; $display("FAIL pass_count_id r%0d: got %b want 1", r, bp_hit_id); end
            dbg_cycle();
        end
    endtask

    task automatic test_mask();
        logic f;
        do_reset();
        cfg(0, 1'b1, 1'b0, 1'b1, 16'h2340, 16'h000F, 8'd0);
        bus(16'h2350, 8'h00, 1, f);
        checks++;
        if (f !== 1'b0) begin errors++; $display("FAIL mask_outside: fired %b want 0", f); end
        bus(16'h234A, 8'h00, 1, f);
        checks++;
        if (f !== 1'b1) begin errors++; $display("FAIL mask_inside: fired %b want 1", f); end
        dbg_cycle();
    endtask

    task automatic test_simultaneous();
        logic f;
        do_reset();
        cfg(0, 1'b1, 1'b0, 1'b0, 16'h0100, 16'h0000, 8'd0);
        cfg(1, 1'b1, 1'b0, 1'b0, 16'h0100, 16'h0000, 8'd0);
        bus(16'h0100, 8'h00, 1, f);
        checks++;
        if (f !== 1'b1 || bp_hit_id !== 1'b0)
            begin errors++; $display("FAIL simul_fire: fired %b id %b want 1 0", f, bp_hit_id); end
        dbg_cycle();
        bus(16'h0100, 8'h00, 1, f);
        checks++;
        if (f !== 1'b0 || bp_hit_id !== 1'b0)
            begin errors++; $display("FAIL simul_disabled: fired %b id %b want 0 0", f, bp_hit_id); end
    endtask

    task automatic test_indebug();
        logic f;
        do_reset();
        cfg(0, 1'b1, 1'b1, 1'b0, 16'h7000, 16'h0FFF, 8'd1);
        INDBG_n = 1'b0;
        tick();
        for (int k = 0; k < 2; k++) begin
            bus(16'h7123, 8'h20, 1, f);
            checks++;
            if (f !== 1'b0) begin errors++; $display("FAIL indebug_ignore k%0d: fired %b want 0", k, f); end
        end
        checks++;
        if (bp_hit_valid !== 1'b0) begin errors++; $display("FAIL indebug_valid: got %b want 0", bp_hit_valid); end
        INDBG_n = 1'b1;
        tick();
        bus(16'h7456, 8'h20, 1, f);
        checks++;
        if (f !== 1'b0) begin errors++; $display("FAIL indebug_count1: fired %b want 0", f); end
        bus(16'h7456, 8'h20, 1, f);
        checks++;
        if (f !== 1'b1) begin errors++; $display("FAIL indebug_count2: fired %b want 1", f); end
        dbg_cycle();
    endtask

    task automatic test_reset_in_fired();
        logic f;
        do_reset();
        cfg(0, 1'b1, 1'b0, 1'b1, 16'h1234, 16'h0000, 8'd0);
        bus(16'h1234, 8'h00, 1, f);
        checks++;
        if (f !== 1'b1) begin errors++; $display("FAIL rst_fired_pre: fired %b want 1", f); end
        RST_n = 1'b0;
        tick();
        RST_n = 1'b1;
        checks++;
        if (DEBUG_n !== 1'b1 || bp_hit_valid !== 1'b0)
            begin errors++; $display("FAIL rst_fired: DEBUG_n %b valid %b want 1 0", DEBUG_n, bp_hit_valid); end
        bus(16'h1234, 8'h00, 1, f);
        checks++;
        if (f !== 1'b0) begin errors++; $display("FAIL rst_fired_slot_off: fired %b want 0", f); end
    endtask

    task automatic test_cfg_collision();
        logic f;
        do_reset();
        cfg(0, 1'b1, 1'b0, 1'b1, 16'h5555, 16'h0000, 8'd0);
        cpu_addr       = 16'h5555;
        data           = 8'h00;
        ADS_n          = 1'b0;
        cfg_sel        = 1'b0;
        cfg_en         = 1'b1;
        cfg_fetch_only = 1'b0;
        cfg_rearm      = 1'b1;
        cfg_addr       = 16'h5555;
        cfg_mask       = 16'h0000;
        cfg_count      = 8'd0;
        cfg_we         = 1'b1;
        tick();
        cfg_we = 1'b0;
        checks++;
        if (DEBUG_n !== 1'b1) begin errors++; $display("FAIL cfg_collision: DEBUG_n %b want 1", DEBUG_n); end
        ADS_n = 1'b1;
        tick();
        bus(16'h5555, 8'h00, 1, f);
        checks++;
        if (f !== 1'b1) begin errors++; $display("FAIL cfg_after_write: fired %b want 1", f); end
        dbg_cycle();
    endtask

    initial begin
        RST_n          = 1'b0;
        ADS_n          = 1'b1;
        data           = 8'h00;
        cpu_addr       = 16'h0000;
        INDBG_n        = 1'b1;
        cfg_we         = 1'b0;
        cfg_sel        = 1'b0;
        cfg_en         = 1'b0;
        cfg_fetch_only = 1'b0;
        cfg_rearm      = 1'b0;
        cfg_addr       = 16'h0000;
        cfg_mask       = 16'h0000;
        cfg_count      = 8'd0;
        test_reset();
        test_basic();
        test_pass_count();
        test_mask();
        test_simultaneous();
        test_indebug();
        test_reset_in_fired();
        test_cfg_collision();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lcds_breakpoint.md
Name: lcds_breakpoint

Overview:
Hardware breakpoint unit on the LCDS board, directly upstream of the debug/address-jamming block. Snoops each SC/MP bus cycle (ADS_n plus the status byte on data) and compares cpu_addr against NUM_BP programmable breakpoints. Each breakpoint has an address mask and a pass count. On a hit it drives DEBUG_n low until the debug block reports entry to debug mode (INDBG_n low), then re-arms or disarms when debug mode is left.

Parameters:
NUM_BP, 2, number of breakpoint slots (1..4)
CNT_W, 8, pass-count width in bits

Ports:
clk  in  1  system clock
RST_n  in  1  reset, synchronous, active-low
ADS_n  in  1  address strobe from CPU, active-low, may stay low for several clk
data  in  8  CPU data bus; status during ADS: bit5=instruction fetch, bit7=halt
cpu_addr  in  16  CPU address bus
INDBG_n  in  1  debug-mode flag from the debug block, active-low
cfg_we  in  1  config write strobe, one clk
cfg_sel  in  $clog2(NUM_BP)  slot selected by cfg_we
cfg_en  in  1  slot enable
cfg_fetch_only  in  1  1 = match instruction fetches only; 0 = any bus cycle
cfg_rearm  in  1  1 = auto re-arm after debug exit; 0 = one-shot
cfg_addr  in  16  breakpoint address
cfg_mask  in  16  don't-care bits (1 = ignore)
cfg_count  in  CNT_W  passes before firing
DEBUG_n  out  1  debug request to the debug block, active-low
bp_hit_id  out  $clog2(NUM_BP)  slot that fired last
bp_hit_valid  out  1  a hit has occurred since reset

Behaviour:
- Reset values: DEBUG_n=1, bp_hit_id=0, bp_hit_valid=0, every slot disabled, addr/mask/count/reload=0, state=ARMED.
- Cycle qualifier: qual = !ADS_n && ADS_n_q, i.e. the first clk that ADS_n is low, using a registered previous value. ADS_n_q resets to 1. A long ADS_n low pulse counts once.
- Slot match: en && qual && ((cpu_addr ^ addr) & ~mask)==0 && (!fetch_only || data[5]).
- Pass counter per slot: on a match with count!=0, count decrements. On a match with count==0 the slot fires. The (cfg_count+1)th match fires; cfg_count=0 fires on the first match. No wrap.
- cfg_we loads addr, mask, en, fetch_only, rearm, count and reload=cfg_count into slot cfg_sel. If cfg_we coincides with a match on the same slot, the write wins and no decrement or fire occurs for that slot.
- FSM (global):
  - ARMED: matches are evaluated. If any slot fires → FIRED. Set bp_hit_id to the lowest-index firing slot. Set bp_hit_valid=1. DEBUG_n goes low on the next clk, so latency is 1 clk from the qual cycle. A firing slot with rearm=0 clears its en.
  - FIRED: DEBUG_n held low. Matches are ignored and no counters change. When INDBG_n=0 → INDEBUG and DEBUG_n returns high the same edge.
  - INDEBUG: DEBUG_n=1. Matches are ignored, so debug-monitor fetches in 0x7xxx never trigger. When INDBG_n returns to 1 → ARMED, and every slot with rearm=1 reloads count from reload.
- If INDBG_n=0 while in ARMED (debug entered by halt switch or halt instruction) → INDEBUG directly. No hit is recorded.
- Simultaneous fire of several slots: the lowest index wins bp_hit_id. All firing slots are treated as fired (count stays 0, one-shot ones disable).
- cfg_we is accepted in any state.
- RST_n low in any state returns everything to reset values on the next edge, including a DEBUG_n held low.

Decomposition:
- Package lcds_bp_pkg:
  - bp_state_t enum {ARMED, FIRED, INDEBUG}
  - bp_cfg_t struct {en, fetch_only, rearm, addr, mask, count}
  - localparam STATUS_FETCH_BIT=5
- Sub-module lcds_bp_slot, instantiated NUM_BP times. It holds one slot's config registers and pass counter, and outputs match/fire.
- The top level holds the ADS_n edge register, the FSM, the priority encoder and the outputs.

Test Plan:
- Slot0 addr=0x1234, mask=0, count=0, fetch_only=1. Fetch cycle at 0x1234 (ADS_n low 3 clk, data[5]=1) → DEBUG_n low exactly 1 clk after the ADS_n falling edge, bp_hit_id=0. Drive INDBG_n=0 → DEBUG_n high next edge.
- count=2, rearm=1. Three fetches at the address → fires on the third only. Exit debug (INDBG_n 0→1), then three more fetches → fires again on the third.
- mask=0x000F, addr=0x2340, fetch_only=0. Read at 0x234A (data[5]=0) → fires. Access at 0x2350 → no fire.
- Slot0 and slot1 both match 0x0100 in the same cycle → bp_hit_id=0. Both one-shot slots are disabled afterwards, and no fire on a repeat after debug exit.
- In INDEBUG, fetches at matching addresses → DEBUG_n stays 1 and counters unchanged. INDBG_n low while ARMED → no hit, bp_hit_valid stays 0.
- In FIRED, assert RST_n=0 for 1 clk → DEBUG_n=1, bp_hit_valid=0, all slots disabled on the next edge. cfg_we to the matching slot in the match cycle → no fire.
